// File: rtl/cache_pkg.sv
// cache_pkg: MESI/op encodings and the default-width line record shared by the L2 set array
package cache_pkg;
    localparam int TAG_W  = 12;
    localparam int DATA_W = 512;
    typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_t;
    typedef enum logic [1:0] {OP_LOOKUP, OP_FILL, OP_WRITE, OP_SETMESI} op_t;
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        mesi_t             mesi;
    } line_t;
endpackage

// File: rtl/cache_set_array_lru.sv
// lru_age_unit: true-LRU age update and victim choice for a single set
module lru_age_unit
    import cache_pkg::*;
#(
    parameter int ways = 8,
    localparam int wayBits = $clog2(ways)
) (
    input  logic [ways-1:0][wayBits-1:0] ages_i,
    input  mesi_t [ways-1:0]             mesi_i,
    input  logic [wayBits-1:0]           way_i,
    output logic [ways-1:0][wayBits-1:0] ages_o,
    output logic [wayBits-1:0]           victim_o
);
    always_comb begin
        for (int i = 0; i < ways; i++)
            ages_o[i] = (wayBits'(i) == way_i) ? '0
                      : (ages_i[i] < ages_i[way_i]) ? ages_i[i] + 1'b1 : ages_i[i];
    end
    // An invalid way (lowest index wins) always beats the oldest valid way
    always_comb begin
        victim_o = '0;
        for (int i = ways - 1; i >= 0; i--)
            if (ages_i[i] == wayBits'(ways - 1)) victim_o = wayBits'(i);
        for (int i = ways - 1; i >= 0; i--)
            if (mesi_i[i] == MESI_I) victim_o = wayBits'(i);
    end
endmodule

// File: rtl/cache_set_array.sv
// cache_set_array: clocked tag/data/MESI/LRU store, one request per cycle, registered response
module cache_set_array
    import cache_pkg::*;
#(
    parameter int indexBits = 14,
    parameter int tagBits   = 12,
    parameter int lineSize  = 512,
    parameter int ways      = 8,
    localparam int wayBits  = $clog2(ways)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic [1:0]           reqOp,
    input  logic [indexBits-1:0] reqIndex,
    input  logic [tagBits-1:0]   reqTag,
    input  logic [lineSize-1:0]  reqData,
    input  logic [1:0]           reqMesi,
    output logic                 respValid,
    input  logic                 respReady,
    output logic                 respHit,
    output logic [wayBits-1:0]   respWay,
    output logic [1:0]           respMesi,
    output logic [tagBits-1:0]   respTag,
    output logic [lineSize-1:0]  respData,
    output logic                 respEvict
);
    localparam int sets = 2 ** indexBits;

    typedef struct packed {
        logic [tagBits-1:0]  tag;
        logic [lineSize-1:0] data;
        mesi_t               mesi;
    } way_line_t;

    typedef struct packed {
        logic                hit;
        logic [wayBits-1:0]  way;
        mesi_t               mesi;
        logic [tagBits-1:0]  tag;
        logic [lineSize-1:0] data;
        logic                evict;
    } resp_t;

    if (ways < 2 || (ways & (ways - 1)) != 0) begin : g_ways_check
        $fatal(1, "cache_set_array: ways must be a power of two >= 2");
    end

    way_line_t                    lines_q [sets][ways];
    logic [ways-1:0][wayBits-1:0] ages_q [sets];
    logic                         resp_valid_q, resp_valid_d;
    resp_t                        resp_q, resp_d;

    way_line_t [ways-1:0]         set_lines;
    mesi_t [ways-1:0]             set_mesi;
    logic [ways-1:0][wayBits-1:0] ages_nxt;
    logic [wayBits-1:0]           hit_way, victim, acc_way;
    logic                         hit, fire, line_we, age_we;
    way_line_t                    old_line, line_d;
    op_t                          op;

    always_comb begin
        op = op_t'(reqOp);
        hit = 1'b0;
        hit_way = '0;
        for (int i = 0; i < ways; i++) begin
            set_lines[i] = lines_q[reqIndex][i];
            set_mesi[i] = set_lines[i].mesi;
            if (set_lines[i].mesi != MESI_I && set_lines[i].tag == reqTag) begin
                hit = 1'b1;
                hit_way = wayBits'(i);
            end
        end
    end

    lru_age_unit #(.ways(ways)) u_lru (
        .ages_i   (ages_q[reqIndex]),
        .mesi_i   (set_mesi),
        .way_i    (acc_way),
        .ages_o   (ages_nxt),
        .victim_o (victim)
    );

    assign reqReady = !resp_valid_q || respReady;

    // Misses address the victim so its old contents are reported and FILL writes it
    always_comb begin
        acc_way = hit ? hit_way : victim;
        old_line = set_lines[acc_way];
        fire = reqValid && reqReady;
        line_we = fire && (op == OP_FILL || (hit && (op == OP_WRITE || op == OP_SETMESI)));
        age_we = fire && (op == OP_FILL || (hit && (op == OP_LOOKUP || op == OP_WRITE)));
        line_d = op == OP_FILL  ? way_line_t'({reqTag, reqData, reqMesi})
               : op == OP_WRITE ? way_line_t'({old_line.tag, reqData, MESI_M})
               :                  way_line_t'({old_line.tag, old_line.data, reqMesi});
        resp_valid_d = fire ? 1'b1 : respReady ? 1'b0 : resp_valid_q;
        resp_d = fire ? resp_t'({hit, acc_way,
                                 op == OP_FILL ? mesi_t'(reqMesi) : old_line.mesi,
                                 old_line.tag, old_line.data,
                                 op == OP_FILL && !hit && old_line.mesi == MESI_M})
                      : resp_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_q <= '0;
            for (int s = 0; s < sets; s++) begin
                for (int w = 0; w < ways; w++) begin
                    lines_q[s][w] <= '0;
                    ages_q[s][w] <= wayBits'(w);
                end
            end
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_q <= resp_d;
            if (line_we) lines_q[reqIndex][acc_way] <= line_d;
            if (age_we) ages_q[reqIndex] <= ages_nxt;
        end
    end

    assign respValid = resp_valid_q;
    assign respHit   = resp_q.hit;
    assign respWay   = resp_q.way;
    assign respMesi  = resp_q.mesi;
    assign respTag   = resp_q.tag;
    assign respData  = resp_q.data;
    assign respEvict = resp_q.evict;
endmodule

// File: doc/cache_set_array.md
# cache_set_array

Clocked, parametrised successor to the combinational cache data-structure block for the L2 cache simulator. It holds tag, line data, 2-bit MESI state and true-LRU age per way for every set. It services one request per cycle through a valid/ready handshake and returns a registered response that carries hit/way, MESI and line data. For fills that displace a Modified line, the response also carries the victim for writeback. It sits between the L2 controller FSM and the shared-bus snoop logic.

## Interface
- `indexBits`, 14, set index width (sets = 2^indexBits)
- `tagBits`, 12, tag width
- `lineSize`, 512, line data width in bits
- `ways`, 8, associativity; power of two, ≥2
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `reqValid`  in  1  request present
- `reqReady`  out  1  request accepted when reqValid && reqReady
- `reqOp`  in  2  0 LOOKUP, 1 FILL, 2 WRITE, 3 SETMESI
- `reqIndex`  in  indexBits  set select
- `reqTag`  in  tagBits  address tag
- `reqData`  in  lineSize  FILL/WRITE data
- `reqMesi`  in  2  FILL/SETMESI state: 0 I, 1 S, 2 E, 3 M
- `respValid`  out  1  response held until respReady
- `respReady`  in  1  consumer accepts response
- `respHit`, `respWay`, `respMesi`  out  1, $clog2(ways), 2  result
- `respTag`, `respData`  out  tagBits, lineSize  hit line, or victim line on miss/evict
- `respEvict`  out  1  FILL displaced a Modified line

## Operation
- Hit: a way whose MESI ≠ I and whose tag equals reqTag. At most one can exist.
- Victim: the lowest-index way with MESI = I. If no such way, the way with age = ways-1.
- LRU update on way w with age a: every way with age < a increments, and w becomes 0. Ages stay a permutation of 0..ways-1.
- LOOKUP, hit: return way, MESI, tag and data; LRU update.
- LOOKUP, miss: respHit=0; return the victim's way, MESI, tag and data. No state change.
- FILL, hit: overwrite that way's data and MESI; respEvict=0.
- FILL, miss: write tag, data and reqMesi into the victim. respEvict=1 iff the victim was M; respTag/respData give the victim's old contents. LRU update on the written way in both cases.
- WRITE, hit: store reqData, set MESI to M, LRU update.
- WRITE, miss: no change; respHit=0.
- SETMESI, hit: set state to reqMesi (I invalidates); no LRU update.
- SETMESI, miss: no change.
- Response fields report pre-update contents except respWay. For a FILL, respMesi reports the new state.

## Timing
- Storage and ages update on the accepting clock edge. The response registers load on that same edge.
- Latency: response valid the cycle after acceptance.
- reqReady = !respValid || respReady, so throughput is one request per cycle and backpressure propagates combinationally.
- While respValid && !respReady, all resp* outputs hold stable.
- Back-to-back requests to the same set see the prior request's updates, with no bypass hazard.
- Reset (asynchronous, any time, including mid-handshake):
  - respValid=0 and every resp* output is 0;
  - all MESI states become I, tags and data 0;
  - ages of way i are set to i;
  - an in-flight response is discarded.
- reqReady returns to 1 while reset is asserted.

## Structure
- Package `cache_pkg`: MESI encoding enum, reqOp enum, and a `line_t` struct (tag, data, mesi). The struct is parametrised through package localparams, with the module overriding widths.
- Sub-module `lru_age_unit`: combinational. Takes the ages of one set, the MESI state of each way and the accessed way. Produces the next ages and the victim way.
- Elaboration-time check: ways must be a power of two ≥2; otherwise `$fatal`.

## Test plan
Bench parameters: indexBits=2, tagBits=4, lineSize=8, ways=4.
- Reset, then LOOKUP idx0 tag3 -> respHit=0, respWay=0, respMesi=I, respValid exactly 1 cycle later.
- FILL idx1 tags 1,2,3,4 with MESI E, data 0x11..0x44 -> ways 0..3 in order; LOOKUP tag1 -> hit way0 data 0x11; ages become way0=0, way1=3.
- WRITE idx1 tag2 data 0xAA -> MESI M. Then touch tags 1, 3, 4. FILL tag5 -> victim way1, respEvict=1, respTag=2, respData=0xAA.
- SETMESI idx1 tag3 to I, then FILL tag6 -> fills way2 (invalid preferred over LRU), respEvict=0.
- Hold respReady=0 for 3 cycles with reqValid=1 -> reqReady=0 and resp* stable; release -> next request accepted the same cycle.
- Assert reset mid-response -> respValid drops immediately; LOOKUP of any prior tag then misses.
